// File: rtl/dcsg_write_arbiter.sv
// rtl/dcsg_write_arbiter.sv - DCSG write capture queue, pacing and mute arbiter (option macro: DCSG_ARB_MUTE_EN)
module dcsg_write_arbiter #(
  parameter logic [7:0] IO_PORT    = 8'h3F,
  parameter int         FIFO_DEPTH = 4,
  parameter int         WR_GAP     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_clk_psg_i,
  input  logic        n_ioreq,
  input  logic        n_wr,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        mute_req,
  output logic        mute_busy,
  output logic        dcsg_wr,
  output logic [7:0]  dcsg_wdata,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic          hit, hit_q, push, push_ok, pop, fifo_empty;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    gap_q;
  logic          slot_free, issue;
  logic          mute_valid;
  logic [7:0]    mute_byte, sel_byte;
  logic          dcsg_wr_q, overflow_q;
  logic [7:0]    dcsg_wdata_q;
  logic          unused_addr_hi;

  // Only the low address byte is decoded on this bus.
  assign unused_addr_hi = ^address[15:8];

  assign hit        = ~n_ioreq & ~n_wr & (address[7:0] == IO_PORT);
  assign push       = hit & ~hit_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign slot_free  = en_clk_psg_i & (gap_q == 8'd0);
  assign issue      = slot_free & (mute_valid | ~fifo_empty);
  assign pop        = issue & ~mute_valid;
  assign push_ok    = push & (~fifo_full | pop);
  assign sel_byte   = mute_valid ? mute_byte : mem_q[rd_ptr_q];

`ifdef DCSG_ARB_MUTE_EN
  typedef enum logic [2:0] {M_IDLE, M_CH0, M_CH1, M_CH2, M_CH3} mute_state_e;
  mute_state_e state_q, state_d;

  // Mute state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= M_IDLE;
    else       state_q <= state_d;
  end

  // Mute sequencing: one attenuation byte per won issue slot, then back to idle.
  always_comb begin
    state_d    = state_q;
    mute_valid = 1'b1;
    mute_byte  = 8'h00;
    case (state_q)
      M_IDLE: begin
        mute_valid = 1'b0;
        if (mute_req) state_d = M_CH0;
      end
      M_CH0: begin
        mute_byte = 8'h9F;
        if (slot_free) state_d = M_CH1;
      end
      M_CH1: begin
        mute_byte = 8'hBF;
        if (slot_free) state_d = M_CH2;
      end
      M_CH2: begin
        mute_byte = 8'hDF;
        if (slot_free) state_d = M_CH3;
      end
      M_CH3: begin
        mute_byte = 8'hFF;
        if (slot_free) state_d = M_IDLE;
      end
      default: begin
        mute_valid = 1'b0;
        state_d    = M_IDLE;
      end
    endcase
  end

  assign mute_busy = (state_q != M_IDLE);
`else
  logic unused_mute_req;
  assign unused_mute_req = mute_req;
  assign mute_valid      = 1'b0;
  assign mute_byte       = 8'h00;
  assign mute_busy       = 1'b0;
`endif

  // Edge register so a long strobe pushes only once.
  always_ff @(posedge clk) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit;
  end

  // Queue storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pacing counter: skip WR_GAP enable pulses after each issued byte.
  always_ff @(posedge clk) begin
    if (reset)                      gap_q <= 8'd0;
    else if (en_clk_psg_i) begin
      if (gap_q != 8'd0)            gap_q <= gap_q - 8'd1;
      else if (issue)               gap_q <= 8'(WR_GAP);
    end
  end

  // Core write strobe, data hold and sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      dcsg_wr_q    <= 1'b0;
      dcsg_wdata_q <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      dcsg_wr_q <= issue;
      if (issue) dcsg_wdata_q <= sel_byte;
      if (push & ~push_ok) overflow_q <= 1'b1;
    end
  end

  assign dcsg_wr    = dcsg_wr_q;
  assign dcsg_wdata = dcsg_wdata_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dcsg_write_arbiter.sv
// tb/tb_dcsg_write_arbiter.sv - self-checking bench for dcsg_write_arbiter
module tb_dcsg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, en_clk_psg_i, n_ioreq, n_wr, mute_req;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        a_busy, a_wr, a_full, a_ovf;
  logic [7:0]  a_wdata;
  logic        b_busy, b_wr, b_full, b_ovf;
  logic [7:0]  b_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_ctr = 0;
  bit en_rand = 0;

  logic [7:0] a_data[$];
  int         a_cyc[$];
  logic [7:0] b_data[$];
  bit b_full_seen, b_busy_seen, b_ff_logged, b_busy_at_ff, b_busy_before_ff, b_prev_busy;

  // Reference model: queue of CPU bytes, queue of pending mute bytes, pacing gap.
  logic [7:0] m_fifo[$];
  logic [7:0] m_mute[$];
  int         m_gap;
  bit         m_hit_prev, m_wr, m_ovf;
  logic [7:0] m_data;

  dcsg_write_arbiter dut (
    .clk(clk), .reset(reset), .en_clk_psg_i(en_clk_psg_i), .n_ioreq(n_ioreq), .n_wr(n_wr),
    .address(address), .wdata(wdata), .mute_req(mute_req), .mute_busy(a_busy),
    .dcsg_wr(a_wr), .dcsg_wdata(a_wdata), .fifo_full(a_full), .overflow(a_ovf)
  );

  dcsg_write_arbiter #(.WR_GAP(31)) dut_g31 (
    .clk(clk), .reset(reset), .en_clk_psg_i(en_clk_psg_i), .n_ioreq(n_ioreq), .n_wr(n_wr),
    .address(address), .wdata(wdata), .mute_req(mute_req), .mute_busy(b_busy),
    .dcsg_wr(b_wr), .dcsg_wdata(b_wdata), .fifo_full(b_full), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit hit, push, idle;
    if (reset) begin
      m_fifo.delete(); m_mute.delete();
      m_gap = 0; m_hit_prev = 0; m_wr = 0; m_ovf = 0; m_data = 8'h00;
      return;
    end
    hit  = !n_ioreq && !n_wr && (address[7:0] == 8'h3F);
    push = hit && !m_hit_prev;
    m_hit_prev = hit;
    idle = (m_mute.size() == 0);
    m_wr = 0;
    if (en_clk_psg_i) begin
      if (m_gap > 0) m_gap--;
      else if (m_mute.size() > 0) begin m_data = m_mute.pop_front(); m_wr = 1; m_gap = 2; end
      else if (m_fifo.size() > 0) begin m_data = m_fifo.pop_front(); m_wr = 1; m_gap = 2; end
    end
`ifdef DCSG_ARB_MUTE_EN
    if (idle && mute_req) begin
      m_mute.push_back(8'h9F); m_mute.push_back(8'hBF);
      m_mute.push_back(8'hDF); m_mute.push_back(8'hFF);
    end
`endif
    if (push) begin
      if (m_fifo.size() < 4) m_fifo.push_back(wdata);
      else m_ovf = 1;
    end
  endtask

  task automatic step();
    if (en_rand) en_clk_psg_i = ($urandom % 3 == 0);
    else         en_clk_psg_i = (en_ctr == 3);
    en_ctr = (en_ctr + 1) % 4;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (a_wr === 1'b1) begin a_data.push_back(a_wdata); a_cyc.push_back(cyc); end
    if (b_wr === 1'b1) b_data.push_back(b_wdata);
    if (b_full === 1'b1) b_full_seen = 1;
    if (b_busy === 1'b1) b_busy_seen = 1;
    if (b_wr === 1'b1 && b_wdata === 8'hFF && !b_ff_logged) begin
      b_ff_logged = 1; b_busy_at_ff = b_busy; b_busy_before_ff = b_prev_busy;
    end
    b_prev_busy = b_busy;
  endtask

  task automatic do_reset();
    reset = 1; n_ioreq = 1; n_wr = 1; mute_req = 0; address = 16'h0000; wdata = 8'h00;
    step(); step();
    reset = 0; en_ctr = 0;
    a_data.delete(); a_cyc.delete(); b_data.delete();
    b_full_seen = 0; b_busy_seen = 0; b_ff_logged = 0; b_busy_at_ff = 0;
    b_busy_before_ff = 0; b_prev_busy = 0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int lo, input int hi);
    address = a; wdata = d; n_ioreq = 0; n_wr = 0;
    repeat (lo) step();
    n_ioreq = 1; n_wr = 1;
    repeat (hi) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 10;
    if (a_wr !== 1'b0)       begin errors++; $display("FAIL reset_wr got=%b exp=0", a_wr); end
    if (a_wdata !== 8'h00)   begin errors++; $display("FAIL reset_wdata got=%h exp=00", a_wdata); end
    if (a_full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", a_full); end
    if (a_ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", a_ovf); end
    if (a_busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    if (b_wr !== 1'b0)       begin errors++; $display("FAIL reset_g31_wr got=%b exp=0", b_wr); end
    if (b_wdata !== 8'h00)   begin errors++; $display("FAIL reset_g31_wdata got=%h exp=00", b_wdata); end
    if (b_full !== 1'b0)     begin errors++; $display("FAIL reset_g31_full got=%b exp=0", b_full); end
    if (b_ovf !== 1'b0)      begin errors++; $display("FAIL reset_g31_ovf got=%b exp=0", b_ovf); end
    if (b_busy !== 1'b0)     begin errors++; $display("FAIL reset_g31_busy got=%b exp=0", b_busy); end
  endtask

  task automatic test_single();
    int t0;
    do_reset();
    t0 = cyc;
    bus_write(16'h003F, 8'h8F, 12, 1);
    repeat (20) step();
    checks += 4;
    if (a_data.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", a_data.size()); end
    if (a_data.size() > 0 && a_data[0] !== 8'h8F) begin errors++; $display("FAIL single_data got=%h exp=8f", a_data[0]); end
    if (a_cyc.size() == 0 || a_cyc[0] - t0 > 7) begin errors++; $display("FAIL single_latency got=%0d exp<=7", (a_cyc.size() > 0) ? a_cyc[0] - t0 : -1); end
    if (a_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf got=%b exp=0", a_ovf); end
  endtask

  task automatic test_wrong_port();
    do_reset();
    bus_write(16'h003E, 8'h55, 12, 1);
    repeat (256) step();
    checks += 2;
    if (a_data.size() != 0) begin errors++; $display("FAIL wrong_port_count got=%0d exp=0", a_data.size()); end
    if (b_data.size() != 0) begin errors++; $display("FAIL wrong_port_g31_count got=%0d exp=0", b_data.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h8F; exp_d[1] = 8'h00; exp_d[2] = 8'h9F;
    do_reset();
    for (int i = 0; i < 3; i++) bus_write(16'h003F, exp_d[i], 12, 1);
    repeat (30) step();
    checks++;
    if (a_data.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", a_data.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= a_data.size() || a_data[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, (i < a_data.size()) ? a_data[i] : 8'hxx, exp_d[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= a_cyc.size() || a_cyc[i] - a_cyc[i-1] != 12) begin
        errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=12", i, (i < a_cyc.size()) ? a_cyc[i] - a_cyc[i-1] : -1);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) bus_write(16'h003F, 8'(i), 12, 1);
    repeat (560) step();
    checks += 3;
    if (!b_full_seen) begin errors++; $display("FAIL ovf_full_seen got=0 exp=1"); end
    if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", b_ovf); end
    if (b_data.size() != 5) begin errors++; $display("FAIL ovf_count got=%0d exp=5", b_data.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= b_data.size() || b_data[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, (i < b_data.size()) ? b_data[i] : 8'hxx, 8'(i + 1));
      end
    end
  endtask

  task automatic test_mute();
    logic [7:0] exp_q[$];
    do_reset();
    bus_write(16'h003F, 8'hA0, 12, 1);
    bus_write(16'h003F, 8'hA1, 12, 1);
    mute_req = 1; step(); mute_req = 0;
    repeat (680) step();
    exp_q.push_back(8'hA0);
`ifdef DCSG_ARB_MUTE_EN
    exp_q.push_back(8'h9F); exp_q.push_back(8'hBF); exp_q.push_back(8'hDF); exp_q.push_back(8'hFF);
`endif
    exp_q.push_back(8'hA1);
    checks++;
    if (b_data.size() != exp_q.size()) begin errors++; $display("FAIL mute_count got=%0d exp=%0d", b_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= b_data.size() || b_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL mute_data[%0d] got=%h exp=%h", i, (i < b_data.size()) ? b_data[i] : 8'hxx, exp_q[i]);
      end
    end
`ifdef DCSG_ARB_MUTE_EN
    checks += 3;
    if (!b_ff_logged) begin errors++; $display("FAIL mute_ff_seen got=0 exp=1"); end
    if (b_busy_before_ff !== 1'b1) begin errors++; $display("FAIL mute_busy_before_ff got=%b exp=1", b_busy_before_ff); end
    if (b_busy_at_ff !== 1'b0) begin errors++; $display("FAIL mute_busy_after_ff got=%b exp=0", b_busy_at_ff); end
`else
    checks++;
    if (b_busy_seen) begin errors++; $display("FAIL mute_busy_seen got=1 exp=0"); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] first_exp;
    int n;
    do_reset();
`ifdef DCSG_ARB_MUTE_EN
    first_exp = 8'h9F;
    mute_req = 1; step(); mute_req = 0;
    bus_write(16'h003F, 8'h8F, 2, 2);
`else
    first_exp = 8'h11;
    bus_write(16'h003F, 8'h11, 2, 1);
    bus_write(16'h003F, 8'h22, 2, 1);
`endif
    n = 0;
    while (a_data.size() == 0 && n < 40) begin step(); n++; end
    checks += 2;
    if (a_data.size() != 1) begin errors++; $display("FAIL midrst_first_count got=%0d exp=1", a_data.size()); end
    if (a_data.size() > 0 && a_data[0] !== first_exp) begin errors++; $display("FAIL midrst_first_data got=%h exp=%h", a_data[0], first_exp); end
    reset = 1; step(); reset = 0;
    checks += 4;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", a_busy); end
    if (a_full !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", a_full); end
    if (a_ovf !== 1'b0)  begin errors++; $display("FAIL midrst_ovf got=%b exp=0", a_ovf); end
    if (a_wr !== 1'b0)   begin errors++; $display("FAIL midrst_wr got=%b exp=0", a_wr); end
    repeat (100) step();
    checks++;
    if (a_data.size() != 1) begin errors++; $display("FAIL midrst_no_more got=%0d exp=1", a_data.size()); end
  endtask

  task automatic test_random();
    int lo_left, idle_left;
    logic exp_full, exp_busy;
    lo_left = 0; idle_left = 0;
    do_reset();
    en_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      mute_req = ($urandom % 50 == 0);
      reset    = ($urandom % 500 == 0);
      if (lo_left == 0 && idle_left == 0) begin
        address = ($urandom % 4 == 0) ? 16'($urandom) : {8'($urandom), 8'h3F};
        wdata   = 8'($urandom);
        n_ioreq = 0;
        n_wr    = ($urandom % 8 == 0);
        lo_left = $urandom_range(1, 8);
      end
      step();
      if (lo_left > 0) begin
        lo_left--;
        if (lo_left == 0) begin n_ioreq = 1; n_wr = 1; idle_left = $urandom_range(1, 6); end
      end else if (idle_left > 0) idle_left--;
      exp_full = (m_fifo.size() == 4);
      exp_busy = (m_mute.size() != 0);
      checks += 5;
      if (a_wr !== m_wr)       begin errors++; $display("FAIL rand_wr cyc=%0d got=%b exp=%b", cyc, a_wr, m_wr); end
      if (a_wdata !== m_data)  begin errors++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, a_wdata, m_data); end
      if (a_full !== exp_full) begin errors++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, a_full, exp_full); end
      if (a_ovf !== m_ovf)     begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, a_ovf, m_ovf); end
      if (a_busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, a_busy, exp_busy); end
    end
    en_rand = 0; reset = 0; mute_req = 0; n_ioreq = 1; n_wr = 1;
  endtask

  initial begin
    reset = 1; en_clk_psg_i = 0; n_ioreq = 1; n_wr = 1; mute_req = 0;
    address = 16'h0000; wdata = 8'h00;
    test_reset();
    test_single();
    test_wrong_port();
    test_back_to_back();
    test_overflow();
    test_mute();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
